// File: rtl/pcpu_panel_pkg.sv
// Shared constants for the CPU front panel: default timing parameters,
// active-low 7-segment patterns and the hex-to-segment decoder.
package pcpu_panel_pkg;

  localparam int DEF_SCAN_DIV = 50000;
  localparam int DEF_DEB_CNT  = 250000;
  localparam int DEF_CNT_W    = 20;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pcpu_panel_debounce.sv
// pcpu_debounce: 2-flop synchroniser plus counter-based debouncer for a
// W-bit word; any change of the synchronised word restarts the count.
module pcpu_debounce
  import pcpu_panel_pkg::*;
#(
  parameter int W       = 1,
  parameter int DEB_CNT = DEF_DEB_CNT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic [W-1:0]     r_sync1, r_sync2, r_last, r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ, w_restart;
  logic [CNT_W-1:0] w_cnt_eff;

  assign w_differ  = (r_sync2 != r_stable);
  // A new differing value (not the one counted last cycle) starts from zero.
  assign w_restart = (r_cnt == '0) || (r_sync2 != r_last);
  assign w_cnt_eff = w_restart ? '0 : r_cnt;

  // NOTE: every flop here uses <= so all of them sample pre-edge values together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_last   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_cnt_eff == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_eff + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/pcpu_panel.sv
// pcpu_panel: debounced select switches and step button, plus 4-digit hex
// display scan of the CPU y word. Define PANEL_DP_SELECT_EN to show select_y on the DPs.
module pcpu_panel
  import pcpu_panel_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEB_CNT  = DEF_DEB_CNT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  sw_select,
  input  logic        btn_step,
  input  logic [15:0] y,
  output logic [3:0]  select_y,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SCAN_DIV - 1);

  logic [3:0]       w_sel;
  logic             w_btn;
  logic             w_wrap;
  logic [3:0]       w_nib;
  logic             r_btn_prev, r_step;
  logic [CNT_W-1:0] r_tick;
  logic [1:0]       r_digit;
  logic             r_first, r_wrap_d;
  logic [15:0]      r_latch;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  pcpu_debounce #(.W(4), .DEB_CNT(DEB_CNT), .CNT_W(CNT_W)) u_deb_sel (
    .clock(clock), .reset(reset), .i_raw(sw_select), .o_stable(w_sel)
  );

  pcpu_debounce #(.W(1), .DEB_CNT(DEB_CNT), .CNT_W(CNT_W)) u_deb_btn (
    .clock(clock), .reset(reset), .i_raw(btn_step), .o_stable(w_btn)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btn_prev <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      r_btn_prev <= w_btn;
      r_step     <= w_btn & ~r_btn_prev;
    end
  end

  assign w_wrap = (r_tick == TICK_LAST);
  assign w_nib  = r_latch[{r_digit, 2'b00} +: 4];

  // Index/latch advance on the wrap; the display registers follow one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick   <= '0;
      r_digit  <= 2'd0;
      r_first  <= 1'b1;
      r_wrap_d <= 1'b0;
      r_latch  <= 16'h0000;
      r_an     <= 4'hF;
      r_seg    <= SEG_BLANK;
      r_dp     <= 1'b1;
    end else begin
      r_wrap_d <= w_wrap;
      if (w_wrap) begin
        r_tick  <= '0;
        r_digit <= r_digit + 2'd1;
        r_first <= 1'b0;
        if (r_first || (r_digit == 2'd3)) r_latch <= y;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
      if (r_wrap_d) begin
        r_an  <= ~(4'b0001 << r_digit);
        r_seg <= hex_to_seg(w_nib);
`ifdef PANEL_DP_SELECT_EN
        r_dp  <= ~w_sel[r_digit];
`else
        r_dp  <= 1'b1;
`endif
      end
    end
  end

  assign select_y   = w_sel;
  assign step_pulse = r_step;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;

endmodule
